// File: rtl/norad_vec_pkg.sv
// Shared definitions for the vector display reader: command codes, word field
// positions, reader FSM states and a small stepping helper.
package norad_vec_pkg;

  typedef enum logic [1:0] {
    CMD_MOVE = 2'd0,
    CMD_DRAW = 2'd1,
    CMD_END  = 2'd2,
    CMD_NOP  = 2'd3
  } vec_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DRAW   = 3'd5
  } rd_state_e;

  localparam int CMD_MSB = 17;
  localparam int CMD_LSB = 16;
  localparam int X_MSB   = 15;
  localparam int X_LSB   = 8;
  localparam int Y_MSB   = 7;
  localparam int Y_LSB   = 0;
  localparam int CNT_W   = 16;

  // True when pos is exactly one unit away from target, so the next step lands on it.
  function automatic logic next_to(input logic [7:0] pos, input logic [7:0] target);
    logic [8:0] p;
    logic [8:0] t;
    p = {1'b0, pos};
    t = {1'b0, target};
    return ((p + 9'd1) == t) || ((t + 9'd1) == p);
  endfunction

endpackage

// File: rtl/vec_axis_stepper.sv
// One beam axis: jumps to the target on load, otherwise moves one unit toward
// it per step_en and holds once there. Never wraps at 0 or 255.
module vec_axis_stepper (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step_en,
  input  logic [7:0] target,
  output logic [7:0] pos,
  output logic       at_target
);

  assign at_target = (pos == target);

  // Position register: load wins over stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= 8'd0;
    end else if (load) begin
      pos <= target;
    end else if (step_en && (pos < target)) begin
      pos <= pos + 8'd1;
    end else if (step_en && (pos > target)) begin
      pos <= pos - 8'd1;
    end else begin
      pos <= pos;
    end
  end

endmodule

// File: rtl/vector_frame_reader.sv
// Walks a vector list one word per address, decodes MOVE/DRAW/END/NOP and
// drives the X/Y DAC codes plus beam blanking for one frame per frame_start.
module vector_frame_reader
  import norad_vec_pkg::*;
#(
  parameter int DATAWIDTH   = 18,
  parameter int ADRESSWIDTH = 8,
  parameter int RD_LATENCY  = 1,
  parameter int SETTLE      = 4,
  parameter int STEP_DIV    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   frame_start,
  output logic [ADRESSWIDTH-1:0] adr_out,
  input  logic [DATAWIDTH-1:0]   data_in,
  output logic [7:0]             dac_x,
  output logic [7:0]             dac_y,
  output logic                   beam_on,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam logic [CNT_W-1:0] LAT_LOAD    = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD    = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [ADRESSWIDTH-1:0] ADR_ONE  = {{(ADRESSWIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADRESSWIDTH-1:0] ADR_ZERO = {ADRESSWIDTH{1'b0}};

  rd_state_e            state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [DATAWIDTH-1:0] word_r;

  vec_cmd_e   cmd_s;
  logic [7:0] tgt_x_s;
  logic [7:0] tgt_y_s;
  logic       x_at_s;
  logic       y_at_s;
  logic       x_fin_s;
  logic       y_fin_s;
  logic       tick_s;
  logic       load_s;
  logic       step_s;
  logic       word_done_s;

  assign cmd_s   = vec_cmd_e'(word_r[CMD_MSB:CMD_LSB]);
  assign tgt_x_s = word_r[X_MSB:X_LSB];
  assign tgt_y_s = word_r[Y_MSB:Y_LSB];
  assign tick_s  = (cnt_r == CNT_ZERO);
  // An axis is finished if it is already there or the step now being taken lands on it.
  assign x_fin_s = x_at_s || next_to(dac_x, tgt_x_s);
  assign y_fin_s = y_at_s || next_to(dac_y, tgt_y_s);

  vec_axis_stepper u_step_x (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .step_en   (step_s),
    .target    (tgt_x_s),
    .pos       (dac_x),
    .at_target (x_at_s)
  );

  vec_axis_stepper u_step_y (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .step_en   (step_s),
    .target    (tgt_y_s),
    .pos       (dac_y),
    .at_target (y_at_s)
  );

  // Stepper strobes and the "current word finished" event.
  always_comb begin
    load_s      = 1'b0;
    step_s      = 1'b0;
    word_done_s = 1'b0;
    case (state_r)
      ST_EXEC: begin
        load_s      = enable && (cmd_s == CMD_MOVE);
        word_done_s = enable && (cmd_s == CMD_NOP);
      end
      ST_SETTLE: begin
        word_done_s = enable && tick_s;
      end
      ST_DRAW: begin
        step_s      = enable && tick_s;
        word_done_s = enable && tick_s && x_fin_s && y_fin_s;
      end
      default: begin
        load_s      = 1'b0;
        step_s      = 1'b0;
        word_done_s = 1'b0;
      end
    endcase
  end

  // Reader FSM with address, latency/settle/step counters and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      word_r     <= {DATAWIDTH{1'b0}};
      adr_out    <= ADR_ZERO;
      beam_on    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      if (!enable) begin
        state_r <= ST_IDLE;
        adr_out <= ADR_ZERO;
        beam_on <= 1'b0;
        busy    <= 1'b0;
      end else if (word_done_s) begin
        beam_on <= 1'b0;
        // The last address without an END closes the frame as if it were END.
        if (&adr_out) begin
          state_r    <= ST_IDLE;
          adr_out    <= ADR_ZERO;
          busy       <= 1'b0;
          frame_done <= 1'b1;
          overrun    <= 1'b1;
        end else begin
          state_r <= ST_FETCH;
          adr_out <= adr_out + ADR_ONE;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (frame_start) begin
              state_r <= ST_FETCH;
              adr_out <= ADR_ZERO;
              busy    <= 1'b1;
            end
          end
          ST_FETCH: begin
            state_r <= ST_WAIT;
            cnt_r   <= LAT_LOAD;
          end
          ST_WAIT: begin
            if (tick_s) begin
              word_r  <= data_in;
              state_r <= ST_EXEC;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          ST_EXEC: begin
            case (cmd_s)
              CMD_MOVE: begin
                state_r <= ST_SETTLE;
                cnt_r   <= SETTLE_LOAD;
              end
              CMD_DRAW: begin
                state_r <= ST_DRAW;
                cnt_r   <= DIV_LOAD;
                beam_on <= 1'b1;
              end
              CMD_END: begin
                state_r    <= ST_IDLE;
                adr_out    <= ADR_ZERO;
                beam_on    <= 1'b0;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
          ST_SETTLE: begin
            cnt_r <= cnt_r - CNT_ONE;
          end
          ST_DRAW: begin
            if (tick_s) begin
              cnt_r <= DIV_LOAD;
            end else begin
              cnt_r <= cnt_r - CNT_ONE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            beam_on <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vector_frame_reader.sv
// Self-checking bench: a list-walking reference model predicts every output per
// cycle of each frame; directed lists pin known timings, then random lists.
module tb_vector_frame_reader;

  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 1;
  localparam int SET    = 4;
  localparam int SDIV   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          frame_start;
  logic [AW-1:0] adr_out;
  logic [17:0]   data_in;
  logic [7:0]    dac_x;
  logic [7:0]    dac_y;
  logic          beam_on;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  logic [17:0] mem [DEPTH];

  typedef struct packed {
    logic [3:0] adr;
    logic [7:0] x;
    logic [7:0] y;
    logic       beam;
    logic       busy;
    logic       done;
    logic       ovr;
  } obs_t;

  obs_t exp_q[$];
  obs_t ce;
  obs_t cd;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_on = 1'b0;
  int   mx = 0;
  int   my = 0;
  int   beam_cnt = 0;
  int   done_cnt = 0;
  int   ovr_cnt = 0;
  int   cyc = 0;
  int   done_at = -1;
  int   exp_len = 0;

  vector_frame_reader #(
    .DATAWIDTH   (18),
    .ADRESSWIDTH (AW),
    .RD_LATENCY  (RD_LAT),
    .SETTLE      (SET),
    .STEP_DIV    (SDIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_start (frame_start),
    .adr_out     (adr_out),
    .data_in     (data_in),
    .dac_x       (dac_x),
    .dac_y       (dac_y),
    .beam_on     (beam_on),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Synchronous list memory, one cycle of read latency.
  always @(posedge clk) data_in <= mem[adr_out];

  function automatic logic [17:0] w(input int cmd, input int x, input int y);
    return {cmd[1:0], x[7:0], y[7:0]};
  endfunction

  function automatic int toward(input int p, input int t);
    return (p < t) ? p + 1 : ((p > t) ? p - 1 : p);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int a, input bit bsy, input bit bm, input bit dn, input bit ov);
    obs_t e;
    e.adr  = a[3:0];
    e.x    = mx[7:0];
    e.y    = my[7:0];
    e.beam = bm;
    e.busy = bsy;
    e.done = dn;
    e.ovr  = ov;
    exp_q.push_back(e);
  endtask

  // Reference model: every word costs address + read latency + execute cycles,
  // then its command-specific cycles; the cycle after the frame carries the pulses.
  task automatic build_trace();
    int a;
    bit fin;
    int cmd;
    int tx;
    int ty;
    int n;
    a = 0;
    fin = 1'b0;
    while (!fin) begin
      cmd = int'(mem[a][17:16]);
      tx  = int'(mem[a][15:8]);
      ty  = int'(mem[a][7:0]);
      repeat (2 + RD_LAT) push(a, 1'b1, 1'b0, 1'b0, 1'b0);
      if (cmd == 2) begin
        push(0, 1'b0, 1'b0, 1'b1, 1'b0);
        fin = 1'b1;
      end else begin
        if (cmd == 0) begin
          mx = tx;
          my = ty;
          repeat (SET) push(a, 1'b1, 1'b0, 1'b0, 1'b0);
        end else if (cmd == 1) begin
          n = (iabs(tx - mx) > iabs(ty - my)) ? iabs(tx - mx) : iabs(ty - my);
          if (n == 0) n = 1;
          repeat (n) begin
            repeat (SDIV) push(a, 1'b1, 1'b1, 1'b0, 1'b0);
            mx = toward(mx, tx);
            my = toward(my, ty);
          end
        end
        if (a == DEPTH - 1) begin
          push(0, 1'b0, 1'b0, 1'b1, 1'b1);
          fin = 1'b1;
        end else begin
          a++;
        end
      end
    end
  endtask

  // Per-cycle compare of every output against the model (idle expectation when no frame is queued).
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      if (exp_q.size() > 0) begin
        ce = exp_q.pop_front();
      end else begin
        ce   = '0;
        ce.x = mx[7:0];
        ce.y = my[7:0];
      end
      cd = {adr_out, dac_x, dac_y, beam_on, busy, frame_done, overrun};
      vectors++;
      if (cd !== ce) begin
        miscompares++;
        $display("FAIL cycle_compare t=%0t: adr/x/y/beam/busy/done/ovr got %0d/%0d/%0d/%b/%b/%b/%b expected %0d/%0d/%0d/%b/%b/%b/%b",
                 $time, cd.adr, cd.x, cd.y, cd.beam, cd.busy, cd.done, cd.ovr,
                 ce.adr, ce.x, ce.y, ce.beam, ce.busy, ce.done, ce.ovr);
      end
      if (beam_on) beam_cnt++;
      if (frame_done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (overrun) ovr_cnt++;
      cyc++;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = w(2, 0, 0);
  endtask

  task automatic run_frame(input bit repulse);
    int guard;
    @(negedge clk);
    build_trace();
    exp_len  = exp_q.size();
    beam_cnt = 0;
    done_cnt = 0;
    ovr_cnt  = 0;
    done_at  = -1;
    cyc      = 0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 4000) begin
      @(negedge clk);
      guard++;
      frame_start = (repulse && guard == 4);
    end
    frame_start = 1'b0;
    check("frame_drain", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic rand_list();
    int gx;
    int gy;
    int len;
    int c;
    int tx;
    int ty;
    bit ovf;
    clear_mem();
    gx  = mx;
    gy  = my;
    ovf = ($urandom_range(0, 5) == 0);
    len = ovf ? DEPTH : int'($urandom_range(2, DEPTH));
    for (int i = 0; i < len; i++) begin
      c = (i == 0) ? 0 : int'($urandom_range(0, 3));
      if (!ovf && i == len - 1) begin
        mem[i] = w(2, 0, 0);
      end else if (c == 0) begin
        case ($urandom_range(0, 3))
          0: tx = 0;
          1: tx = 255;
          default: tx = int'($urandom_range(0, 255));
        endcase
        ty = ($urandom_range(0, 2) == 0) ? 255 - tx : int'($urandom_range(0, 255));
        mem[i] = w(0, tx, ty);
        gx = tx;
        gy = ty;
      end else if (c == 3) begin
        mem[i] = w(3, 0, 0);
      end else begin
        tx = gx + int'($urandom_range(0, 24)) - 12;
        ty = gy + int'($urandom_range(0, 24)) - 12;
        tx = (tx < 0) ? 0 : ((tx > 255) ? 255 : tx);
        ty = (ty < 0) ? 0 : ((ty > 255) ? 255 : ty);
        mem[i] = w(1, tx, ty);
        gx = tx;
        gy = ty;
      end
    end
  endtask

  initial begin
    int guard;
    int seen;
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int guard;
    int seen;
    rst_n = 1'b0;
    enable = 1'b0;
    frame_start = 1'b0;
    clear_mem();
    #1;
    check("reset_outputs", int'({adr_out, dac_x, dac_y, beam_on, busy, frame_done, overrun} != 24'd0), 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);

    // Single MOVE then END: no beam, done after 10 cycles.
    clear_mem();
    mem[0] = w(0, 10, 20);
    run_frame(1'b0);
    check("t1_model_len", exp_len, 11);
    check("t1_done_cycle", done_at, 10);
    check("t1_beam_cycles", beam_cnt, 0);
    check("t1_dac_x", int'(dac_x), 10);
    check("t1_dac_y", int'(dac_y), 20);

    // Line from origin to (3,1).
    clear_mem();
    mem[0] = w(0, 0, 0);
    mem[1] = w(1, 3, 1);
    run_frame(1'b0);
    check("t2_model_len", exp_len, 20);
    check("t2_beam_cycles", beam_cnt, 6);
    check("t2_dac_x", int'(dac_x), 3);
    check("t2_dac_y", int'(dac_y), 1);

    // Dot plus two NOPs.
    clear_mem();
    mem[0] = w(0, 5, 5);
    mem[1] = w(1, 5, 5);
    mem[2] = w(3, 0, 0);
    mem[3] = w(3, 0, 0);
    run_frame(1'b0);
    check("t3_model_len", exp_len, 22);
    check("t3_beam_cycles", beam_cnt, 2);
    check("t3_dac_x", int'(dac_x), 5);

    // No END anywhere: overrun after the last address.
    for (int i = 0; i < DEPTH; i++) mem[i] = w(3, 0, 0);
    run_frame(1'b0);
    check("t5_model_len", exp_len, 49);
    check("t5_overrun_pulses", ovr_cnt, 1);
    check("t5_done_pulses", done_cnt, 1);
    check("t5_done_cycle", done_at, 48);

    // frame_start re-pulsed while busy is ignored.
    clear_mem();
    mem[0] = w(0, 30, 40);
    run_frame(1'b1);
    check("t6_done_pulses", done_cnt, 1);

    for (int f = 0; f < 30; f++) begin
      rand_list();
      run_frame(f % 7 == 3);
      check("rand_done_pulses", done_cnt, 1);
    end

    // Enable dropped mid-draw at (2,0).
    chk_on = 1'b0;
    clear_mem();
    mem[0] = w(0, 0, 0);
    mem[1] = w(1, 5, 0);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    guard = 0;
    while (!(beam_on && dac_x == 8'd2) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("t4_reach_2_0", int'(guard < 200), 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("t4_beam_off", int'(beam_on), 0);
    check("t4_busy_off", int'(busy), 0);
    check("t4_hold_x", int'(dac_x), 2);
    check("t4_hold_y", int'(dac_y), 0);
    seen = int'(frame_done);
    repeat (5) begin
      @(posedge clk);
      #1;
      seen = seen | int'(frame_done);
    end
    check("t4_no_done", seen, 0);
    @(negedge clk);
    enable = 1'b1;
    mx = 2;
    my = 0;
    exp_q.delete();
    chk_on = 1'b1;
    clear_mem();
    mem[0] = w(0, 40, 50);
    run_frame(1'b0);
    check("t4_restart_x", int'(dac_x), 40);
    check("t4_restart_y", int'(dac_y), 50);

    // Asynchronous reset in the middle of a draw.
    chk_on = 1'b0;
    clear_mem();
    mem[0] = w(0, 9, 9);
    mem[1] = w(1, 20, 9);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    guard = 0;
    while (!beam_on && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("t6_reach_draw", int'(guard < 200), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", int'({adr_out, dac_x, dac_y, beam_on, busy, frame_done, overrun} != 24'd0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mx = 0;
    my = 0;
    exp_q.delete();
    chk_on = 1'b1;
    rand_list();
    run_frame(1'b0);
    check("post_reset_done", done_cnt, 1);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
